// File: rtl/mcu_config_rx_pkg.sv
// Shared definitions for the MCU serial receive path: UART and packet
// parser state encodings plus the default bit period.
package mcu_config_rx_pkg;

    // 50 MHz sys_clock / 500 kbaud
    localparam int DEF_CLK_PER_BIT = 100;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HI
    } uart_state_e;

    typedef enum logic [1:0] {
        P_ADDR,
        P_DATA,
        P_SUM
    } parser_state_e;

endpackage

// File: rtl/mcu_config_rx_serial_rx_byte.sv
// 8N1 byte receiver: two-flop rx synchronizer plus oversampling UART FSM.
// Bits are sampled mid-period; the receiver is held in IDLE while the link
// is not ready, so a partial byte is silently dropped.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | line idle, waiting for a falling edge on rx
//  START   | half a bit in, confirm start bit is still low (glitch reject)
//  DATA    | sample 8 data bits LSB first, one per bit period
//  STOP    | sample stop bit; high -> byte strobe, low -> framing error
//  WAIT_HI | line held low after a framing error, wait for it to return
module mcu_config_rx_serial_rx_byte
    import mcu_config_rx_pkg::*;
#(
    parameter int CLK_PER_BIT = DEF_CLK_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       new_rx_data,
    output logic       framing_err
);

    localparam int CTR_W = $clog2(CLK_PER_BIT);
    localparam logic [CTR_W-1:0] HALF_M1 = CTR_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CTR_W-1:0] FULL_M1 = CTR_W'(CLK_PER_BIT - 1);

    uart_state_e      state_q, state_d;
    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             new_q, new_d;
    logic             ferr_q, ferr_d;
    logic             rx_meta_q, rx_s_q;

    // Next-state and strobe generation for the UART FSM
    always_comb begin
        state_d   = state_q;
        ctr_d     = ctr_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        new_d     = 1'b0;
        ferr_d    = 1'b0;
        if (!ready) begin
            state_d = IDLE;
            ctr_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_d = START;
                        ctr_d   = '0;
                    end
                end
                START: begin
                    if (ctr_q == HALF_M1) begin
                        ctr_d   = '0;
                        bit_d   = '0;
                        state_d = rx_s_q ? IDLE : DATA;
                    end else begin
                        ctr_d = ctr_q + 1'b1;
                    end
                end
                DATA: begin
                    if (ctr_q == FULL_M1) begin
                        ctr_d   = '0;
                        shift_d = {rx_s_q, shift_q[7:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end else begin
                        ctr_d = ctr_q + 1'b1;
                    end
                end
                STOP: begin
                    if (ctr_q == FULL_M1) begin
                        ctr_d = '0;
                        if (rx_s_q) begin
                            rx_data_d = shift_q;
                            new_d     = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = WAIT_HI;
                        end
                    end else begin
                        ctr_d = ctr_q + 1'b1;
                    end
                end
                WAIT_HI: begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Synchronizer and FSM registers; the rx sync idles high like the line
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            ctr_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rx_data_q <= '0;
            new_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            ctr_q     <= ctr_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            new_q     <= new_d;
            ferr_q    <= ferr_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign new_rx_data = new_q;
    assign framing_err = ferr_q;

endmodule

// File: rtl/mcu_config_rx.sv
// MCU serial link receive path: cclk-qualified ready, 8N1 byte receiver and
// register-write packet parser (addr, data) with an inter-byte timeout.
// Optional feature: define MCU_RX_CHECKSUM_EN for 3-byte packets carrying
// an addr^data checksum; otherwise cksum_err is tied low.
module mcu_config_rx
    import mcu_config_rx_pkg::*;
#(
    parameter int CLK_PER_BIT    = DEF_CLK_PER_BIT,
    parameter int READY_CYCLES   = 512,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cclk,
    input  logic       rx,
    output logic       ready,
    output logic [7:0] rx_data,
    output logic       new_rx_data,
    output logic       framing_err,
    output logic       reg_wr_valid,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_data,
    output logic       cksum_err
);

    localparam int RDY_W = $clog2(READY_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RDY_W-1:0] READY_MAX = RDY_W'(READY_CYCLES);
    localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT_CYCLES);

    logic             cclk_meta_q, cclk_s_q;
    logic [RDY_W-1:0] rdy_cnt_q, rdy_cnt_d;
    parser_state_e    pstate_q, pstate_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [7:0]       addr_lat_q, addr_lat_d;
    logic [7:0]       reg_addr_q, reg_addr_d;
    logic [7:0]       reg_data_q, reg_data_d;
    logic             wr_q, wr_d;
`ifdef MCU_RX_CHECKSUM_EN
    logic [7:0]       data_lat_q, data_lat_d;
    logic             cks_q, cks_d;
`endif

    logic [7:0] rx_byte;
    logic       rx_new;
    logic       rx_ferr;

    mcu_config_rx_serial_rx_byte #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_rx_byte (
        .clk         (clk),
        .rst         (rst),
        .ready       (ready),
        .rx          (rx),
        .rx_data     (rx_byte),
        .new_rx_data (rx_new),
        .framing_err (rx_ferr)
    );

    // Ready counter saturates at READY_CYCLES; any low cclk sample clears it
    always_comb begin
        rdy_cnt_d = rdy_cnt_q;
        if (!cclk_s_q) begin
            rdy_cnt_d = '0;
        end else if (rdy_cnt_q != READY_MAX) begin
            rdy_cnt_d = rdy_cnt_q + 1'b1;
        end
    end

    // Packet parser and inter-byte timeout; a new byte beats a timeout
    always_comb begin
        pstate_d   = pstate_q;
        to_cnt_d   = to_cnt_q;
        addr_lat_d = addr_lat_q;
        reg_addr_d = reg_addr_q;
        reg_data_d = reg_data_q;
        wr_d       = 1'b0;
`ifdef MCU_RX_CHECKSUM_EN
        data_lat_d = data_lat_q;
        cks_d      = 1'b0;
`endif
        if (!ready || rx_ferr) begin
            pstate_d = P_ADDR;
            to_cnt_d = '0;
        end else if (rx_new) begin
            to_cnt_d = '0;
            case (pstate_q)
                P_ADDR: begin
                    addr_lat_d = rx_byte;
                    pstate_d   = P_DATA;
                end
                P_DATA: begin
`ifdef MCU_RX_CHECKSUM_EN
                    data_lat_d = rx_byte;
                    pstate_d   = P_SUM;
`else
                    reg_addr_d = addr_lat_q;
                    reg_data_d = rx_byte;
                    wr_d       = 1'b1;
                    pstate_d   = P_ADDR;
`endif
                end
`ifdef MCU_RX_CHECKSUM_EN
                P_SUM: begin
                    if (rx_byte == (addr_lat_q ^ data_lat_q)) begin
                        reg_addr_d = addr_lat_q;
                        reg_data_d = data_lat_q;
                        wr_d       = 1'b1;
                    end else begin
                        cks_d = 1'b1;
                    end
                    pstate_d = P_ADDR;
                end
`endif
                default: pstate_d = P_ADDR;
            endcase
        end else if (pstate_q != P_ADDR) begin
            if (to_cnt_q == TO_MAX) begin
                pstate_d = P_ADDR;
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    // cclk synchronizer, ready counter and parser registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cclk_meta_q <= 1'b0;
            cclk_s_q    <= 1'b0;
            rdy_cnt_q   <= '0;
            pstate_q    <= P_ADDR;
            to_cnt_q    <= '0;
            addr_lat_q  <= '0;
            reg_addr_q  <= '0;
            reg_data_q  <= '0;
            wr_q        <= 1'b0;
`ifdef MCU_RX_CHECKSUM_EN
            data_lat_q  <= '0;
            cks_q       <= 1'b0;
`endif
        end else begin
            cclk_meta_q <= cclk;
            cclk_s_q    <= cclk_meta_q;
            rdy_cnt_q   <= rdy_cnt_d;
            pstate_q    <= pstate_d;
            to_cnt_q    <= to_cnt_d;
            addr_lat_q  <= addr_lat_d;
            reg_addr_q  <= reg_addr_d;
            reg_data_q  <= reg_data_d;
            wr_q        <= wr_d;
`ifdef MCU_RX_CHECKSUM_EN
            data_lat_q  <= data_lat_d;
            cks_q       <= cks_d;
`endif
        end
    end

    assign ready        = (rdy_cnt_q == READY_MAX);
    assign rx_data      = rx_byte;
    assign new_rx_data  = rx_new;
    assign framing_err  = rx_ferr;
    assign reg_wr_valid = wr_q;
    assign reg_addr     = reg_addr_q;
    assign reg_data     = reg_data_q;
`ifdef MCU_RX_CHECKSUM_EN
    assign cksum_err    = cks_q;
`else
    assign cksum_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mcu_config_rx.sv
// Directed bench for mcu_config_rx: ready qualification, byte reception,
// framing error, glitch rejection, packet timeout and (when built with
// MCU_RX_CHECKSUM_EN) checksum handling.
module tb_mcu_config_rx;

    localparam int CPB     = 100;
    localparam int TIMEOUT = 20000;

    logic       clk = 1'b0;
    logic       rst;
    logic       cclk;
    logic       rx;
    logic       ready;
    logic [7:0] rx_data;
    logic       new_rx_data;
    logic       framing_err;
    logic       reg_wr_valid;
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
    logic       cksum_err;

    always #5 clk = ~clk;

    mcu_config_rx dut (
        .clk          (clk),
        .rst          (rst),
        .cclk         (cclk),
        .rx           (rx),
        .ready        (ready),
        .rx_data      (rx_data),
        .new_rx_data  (new_rx_data),
        .framing_err  (framing_err),
        .reg_wr_valid (reg_wr_valid),
        .reg_addr     (reg_addr),
        .reg_data     (reg_data),
        .cksum_err    (cksum_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Strobe monitor, sampled on the falling edge
    int         cyc = 0;
    int         new_cnt = 0, ferr_cnt = 0, wr_cnt = 0, cks_cnt = 0;
    int         new_cyc = 0;
    logic [7:0] last_rx = '0, wr_addr = '0, wr_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (new_rx_data) begin
            new_cnt++;
            last_rx = rx_data;
            new_cyc = cyc;
        end
        if (framing_err) ferr_cnt++;
        if (cksum_err) cks_cnt++;
        if (reg_wr_valid) begin
            wr_cnt++;
            wr_addr = reg_addr;
            wr_data = reg_data;
        end
    end

    int start_cyc = 0;
    int b_new, b_ferr, b_wr, b_cks;

    task automatic snap();
        b_new  = new_cnt;
        b_ferr = ferr_cnt;
        b_wr   = wr_cnt;
        b_cks  = cks_cnt;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        start_cyc = cyc;
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [7:0] a, input logic [7:0] d);
        send_byte(a, 1'b1);
        send_byte(d, 1'b1);
`ifdef MCU_RX_CHECKSUM_EN
        send_byte(a ^ d, 1'b1);
`endif
    endtask

    initial begin
        int lat;
        rst  = 1'b1;
        cclk = 1'b0;
        rx   = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_new", 32'(new_rx_data), 0);
        chk("rst_ferr", 32'(framing_err), 0);
        chk("rst_wr", 32'(reg_wr_valid), 0);
        chk("rst_addr", 32'(reg_addr), 0);
        chk("rst_data", 32'(reg_data), 0);
        chk("rst_cks", 32'(cksum_err), 0);
        @(negedge clk);
        rst = 1'b0;

        // 1. ready qualification: 2 sync edges + 512 counting edges
        @(negedge clk);
        cclk = 1'b1;
        repeat (513) @(posedge clk);
        #1 chk("ready_at_511", 32'(ready), 0);
        @(posedge clk);
        #1 chk("ready_at_512", 32'(ready), 1);

        snap();
        @(negedge clk);
        rx = 1'b0;
        repeat (300) @(negedge clk);
        cclk = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("ready_drop", 32'(ready), 0);
        @(negedge clk);
        rx = 1'b1;
        repeat (1200) @(negedge clk);
        chk("inflight_no_new", 32'(new_cnt - b_new), 0);
        chk("inflight_no_ferr", 32'(ferr_cnt - b_ferr), 0);
        cclk = 1'b1;
        repeat (520) @(negedge clk);
        chk("ready_again", 32'(ready), 1);

        // 2. basic packet 0x12 / 0x34
        snap();
        send_byte(8'h12, 1'b1);
        chk("b1_new_cnt", 32'(new_cnt - b_new), 1);
        chk("b1_rx_data", 32'(last_rx), 32'h12);
        lat = new_cyc - start_cyc;
        chk("b1_latency_ok", 32'(lat >= 951 && lat <= 953), 1);
        chk("b1_no_wr", 32'(wr_cnt - b_wr), 0);
        send_byte(8'h34, 1'b1);
        chk("b2_rx_data", 32'(last_rx), 32'h34);
        chk("b2_new_cnt", 32'(new_cnt - b_new), 2);
`ifdef MCU_RX_CHECKSUM_EN
        send_byte(8'h26, 1'b1);
`endif
        chk("p1_wr_cnt", 32'(wr_cnt - b_wr), 1);
        chk("p1_wr_addr", 32'(wr_addr), 32'h12);
        chk("p1_wr_data", 32'(wr_data), 32'h34);
        chk("p1_hold_addr", 32'(reg_addr), 32'h12);
        chk("p1_hold_data", 32'(reg_data), 32'h34);

        // 3. framing error mid-packet resets parser
        snap();
        send_byte(8'h77, 1'b1);
        send_byte(8'h55, 1'b0);
        chk("fe_ferr_cnt", 32'(ferr_cnt - b_ferr), 1);
        chk("fe_new_cnt", 32'(new_cnt - b_new), 1);
        send_pkt(8'hA0, 8'h0F);
        chk("fe_wr_cnt", 32'(wr_cnt - b_wr), 1);
        chk("fe_wr_addr", 32'(wr_addr), 32'hA0);
        chk("fe_wr_data", 32'(wr_data), 32'h0F);

        // 4. 30-cycle glitch is rejected, receiver still works after
        snap();
        @(negedge clk);
        rx = 1'b0;
        repeat (30) @(negedge clk);
        rx = 1'b1;
        repeat (1200) @(negedge clk);
        chk("gl_new_cnt", 32'(new_cnt - b_new), 0);
        chk("gl_ferr_cnt", 32'(ferr_cnt - b_ferr), 0);
        send_pkt(8'h3C, 8'hC3);
        chk("gl_wr_addr", 32'(wr_addr), 32'h3C);
        chk("gl_wr_data", 32'(wr_data), 32'hC3);

        // 5. inter-byte timeout drops a dangling address
        snap();
        send_byte(8'h12, 1'b1);
        repeat (TIMEOUT + 10) @(negedge clk);
        chk("to_no_wr", 32'(wr_cnt - b_wr), 0);
        send_pkt(8'h34, 8'h56);
        chk("to_wr_cnt", 32'(wr_cnt - b_wr), 1);
        chk("to_wr_addr", 32'(wr_addr), 32'h34);
        chk("to_wr_data", 32'(wr_data), 32'h56);

`ifdef MCU_RX_CHECKSUM_EN
        // 6. bad checksum: error strobe, no write
        snap();
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h00, 1'b1);
        chk("ck_err_cnt", 32'(cks_cnt - b_cks), 1);
        chk("ck_no_wr", 32'(wr_cnt - b_wr), 0);
`else
        chk("no_cksum_err", 32'(cks_cnt), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
